booth_arbiter: RTL and testbench
================================

BOOTH_ARBITER -- requirements
Module: booth_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width of the shared Booth multiplier.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum cycles to wait for m_Finish after m_Start rises.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: Resetn  input  1  synchronous, active-low reset.
REQ-005 Ports: req0, req1  input  1 each  request from requester 0 and requester 1.
REQ-006 Ports: mplier0, mcand0, mplier1, mcand1  input  N each  signed operands of each requester.
REQ-007 Ports: done0, done1  output  1 each  one-cycle completion pulse per requester.
REQ-008 Ports: err0, err1  output  1 each  one-cycle timeout pulse per requester.
REQ-009 Port: result  output  2N  product of the most recently completed operation.
REQ-010 Port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 Ports: m_Start  output  1; m_Mplier, m_Mcand  output  N  drive the multiplier.
REQ-012 Ports: m_Finish  input  1; m_Product  input  2N  returned by the multiplier.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, WAIT_FIN, COMPLETE and RELEASE.
REQ-014 Every output SHALL be registered.
REQ-015 IDLE: when any req is high, the FSM SHALL grant one requester and capture its operands into m_Mplier/m_Mcand, then go to ISSUE on the next edge.
REQ-016 Arbitration SHALL be round-robin: with both req high, grant the requester pointed to by prio.
REQ-017 prio SHALL point to the other requester after each completed or timed-out grant.
REQ-018 With a single req high, that requester SHALL be granted regardless of prio.
REQ-019 ISSUE: m_Start SHALL be 1, the timeout counter SHALL clear, and the FSM SHALL go to WAIT_FIN.
REQ-020 WAIT_FIN: m_Start SHALL stay 1 until m_Finish is sampled high, then the FSM SHALL latch m_Product into result and go to COMPLETE.
REQ-021 WAIT_FIN: if the counter reaches TIMEOUT before m_Finish is sampled high, the FSM SHALL go to COMPLETE flagged as error, and result SHALL be unchanged.
REQ-022 COMPLETE: m_Start SHALL be 0 for exactly one cycle, and the block SHALL pulse done of the granted requester (success) or err of the granted requester (timeout), never both.
REQ-023 RELEASE: the FSM SHALL wait for m_Finish low, then return to IDLE; done/err SHALL be 0 in RELEASE.
REQ-024 m_Mplier and m_Mcand SHALL stay stable from grant until RELEASE exits.
REQ-025 Operands SHALL be captured only at grant; requester operands may change afterwards without effect.
REQ-026 A requester SHALL deassert req in the cycle after its done/err pulse; a req still high when the FSM next reaches IDLE SHALL be treated as a new request.
REQ-027 Requests arriving while busy SHALL be held pending and SHALL NOT be lost or reorder the current grant.
REQ-028 result SHALL pass m_Product bit-exact (2N bits, two's complement); the block SHALL perform no arithmetic on it.
REQ-029 Minimum request-to-done latency SHALL be 4 cycles plus the multiplier latency.

Reset
REQ-030 While Resetn is low at a clock edge, the next state SHALL be: FSM IDLE, prio=0, m_Start=0, m_Mplier=0, m_Mcand=0, result=0, done0/1=0, err0/1=0, busy=0, counter=0.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no done or err pulse; the multiplier SHALL see m_Start=0 from the next edge.

Verification
REQ-032 Single req0 with mplier0=8'h03, mcand0=8'h05 -> m_Start high until m_Finish, then done0 pulse with result=16'h000F, and done1 stays 0.
REQ-033 req1 with mplier1=8'hFD, mcand1=8'h05 -> done1 pulse with result=16'hFFF1.
REQ-034 req0 and req1 raised in the same cycle after reset, held, with operands (2,3) and (4,5) -> requester 0 served first (result 16'h0006), then requester 1 (result 16'h0014), with the grant alternating on further simultaneous requests.
REQ-035 Multiplier model that never raises m_Finish -> err0 pulse TIMEOUT cycles after ISSUE, result unchanged, m_Start low, and FSM back in IDLE.
REQ-036 Resetn pulled low while in WAIT_FIN -> all outputs return to the reset values of REQ-030, with no done or err pulse, and a subsequent request completes normally.
REQ-037 Operands changed the cycle after grant, with mplier0=8'h80 and mcand0=8'h80 -> m_Mplier/m_Mcand hold the captured values and result=16'h4000.

Source files
------------

// File: rtl/booth_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier between two requesters.
// Operands are captured at grant; a stuck multiplier is cut off after TIMEOUT cycles.
module booth_arbiter #(
   parameter int unsigned N       = 8,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           Resetn,
   input  logic           req0,
   input  logic           req1,
   input  logic [N-1:0]   mplier0,
   input  logic [N-1:0]   mcand0,
   input  logic [N-1:0]   mplier1,
   input  logic [N-1:0]   mcand1,
   output logic           done0,
   output logic           done1,
   output logic           err0,
   output logic           err1,
   output logic [2*N-1:0] result,
   output logic           busy,
   output logic           m_Start,
   output logic [N-1:0]   m_Mplier,
   output logic [N-1:0]   m_Mcand,
   input  logic           m_Finish,
   input  logic [2*N-1:0] m_Product
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitFin,
      StComplete,
      StRelease
   } state_e;

   state_e           state_q, state_d;
   logic             prio_q, prio_d;
   logic             grant_q, grant_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             m_start_q, m_start_d;
   logic [N-1:0]     m_mplier_q, m_mplier_d;
   logic [N-1:0]     m_mcand_q, m_mcand_d;
   logic [2*N-1:0]   result_q, result_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   logic             err0_q, err0_d;
   logic             err1_q, err1_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      grant_d    = grant_q;
      cnt_d      = cnt_q;
      m_mplier_d = m_mplier_q;
      m_mcand_d  = m_mcand_q;
      result_d   = result_q;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      err0_d     = 1'b0;
      err1_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               // prio only matters on a tie; a lone request always wins
               grant_d    = (req0 && req1) ? prio_q : req1;
               m_mplier_d = grant_d ? mplier1 : mplier0;
               m_mcand_d  = grant_d ? mcand1 : mcand0;
               state_d    = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWaitFin;
         end
         StWaitFin: begin
            if (m_Finish) begin
               result_d = m_Product;
               done0_d  = ~grant_q;
               done1_d  = grant_q;
               prio_d   = ~grant_q;
               state_d  = StComplete;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               err0_d  = ~grant_q;
               err1_d  = grant_q;
               prio_d  = ~grant_q;
               state_d = StComplete;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StComplete: begin
            state_d = StRelease;
         end
         StRelease: begin
            if (!m_Finish) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Registered outputs follow the state being entered
      m_start_d = (state_d == StIssue) || (state_d == StWaitFin);
      busy_d    = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (!Resetn) begin
         state_q    <= StIdle;
         prio_q     <= 1'b0;
         grant_q    <= 1'b0;
         cnt_q      <= '0;
         m_start_q  <= 1'b0;
         m_mplier_q <= '0;
         m_mcand_q  <= '0;
         result_q   <= '0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         err0_q     <= 1'b0;
         err1_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         grant_q    <= grant_d;
         cnt_q      <= cnt_d;
         m_start_q  <= m_start_d;
         m_mplier_q <= m_mplier_d;
         m_mcand_q  <= m_mcand_d;
         result_q   <= result_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         err0_q     <= err0_d;
         err1_q     <= err1_d;
         busy_q     <= busy_d;
      end
   end

   assign m_Start  = m_start_q;
   assign m_Mplier = m_mplier_q;
   assign m_Mcand  = m_mcand_q;
   assign result   = result_q;
   assign done0    = done0_q;
   assign done1    = done1_q;
   assign err0     = err0_q;
   assign err1     = err1_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// Directed bench for booth_arbiter with a behavioural fixed-latency multiplier model.
module tb_booth_arbiter;

   localparam int unsigned N       = 8;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned MulLat  = 2;

   logic           clk = 1'b0;
   logic           Resetn;
   logic           req0, req1;
   logic [N-1:0]   mplier0, mcand0, mplier1, mcand1;
   logic           done0, done1, err0, err1;
   logic [2*N-1:0] result;
   logic           busy;
   logic           m_Start;
   logic [N-1:0]   m_Mplier, m_Mcand;
   logic           m_Finish;
   logic [2*N-1:0] m_Product;

   logic           never_fin;
   int unsigned    lat_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] flags;
   int         cyc;

   booth_arbiter #(
      .N       (N),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .Resetn    (Resetn),
      .req0      (req0),
      .req1      (req1),
      .mplier0   (mplier0),
      .mcand0    (mcand0),
      .mplier1   (mplier1),
      .mcand1    (mcand1),
      .done0     (done0),
      .done1     (done1),
      .err0      (err0),
      .err1      (err1),
      .result    (result),
      .busy      (busy),
      .m_Start   (m_Start),
      .m_Mplier  (m_Mplier),
      .m_Mcand   (m_Mcand),
      .m_Finish  (m_Finish),
      .m_Product (m_Product)
   );

   always #5 clk = ~clk;

   // Multiplier: finish a few cycles after start, hold finish until start drops
   always @(posedge clk) begin
      if (!Resetn || !m_Start) begin
         m_Finish <= 1'b0;
         lat_cnt  <= 0;
      end else if (!never_fin) begin
         if (lat_cnt == MulLat) begin
            m_Finish  <= 1'b1;
            m_Product <= $signed(m_Mplier) * $signed(m_Mcand);
         end else begin
            lat_cnt <= lat_cnt + 1;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // flags = {err1, err0, done1, done0}; all zero if the budget expires
   task automatic wait_pulse(input int budget, output logic [3:0] f, output int cycles);
      f      = 4'b0000;
      cycles = 0;
      while (f == 4'b0000 && cycles < budget) begin
         @(negedge clk);
         cycles++;
         f = {err1, err0, done1, done0};
      end
   endtask

   task automatic wait_idle(input string tag);
      int c;
      c = 0;
      while (busy !== 1'b0 && c < 20) begin
         @(negedge clk);
         c++;
      end
      check_eq(tag, {31'b0, busy}, 32'h0);
   endtask

   task automatic set_op(input int sel, input logic [N-1:0] mp, input logic [N-1:0] mc);
      if (sel == 0) begin
         mplier0 = mp;
         mcand0  = mc;
         req0    = 1'b1;
      end else begin
         mplier1 = mp;
         mcand1  = mc;
         req1    = 1'b1;
      end
   endtask

   initial begin
      Resetn    = 1'b0;
      req0      = 1'b0;
      req1      = 1'b0;
      mplier0   = '0;
      mcand0    = '0;
      mplier1   = '0;
      mcand1    = '0;
      never_fin = 1'b0;
      m_Product = '0;
      repeat (2) @(negedge clk);

      check_eq("rst_busy", {31'b0, busy}, 32'h0);
      check_eq("rst_start", {31'b0, m_Start}, 32'h0);
      check_eq("rst_ops", {16'b0, m_Mplier, m_Mcand}, 32'h0);
      check_eq("rst_result", {16'b0, result}, 32'h0);
      check_eq("rst_flags", {28'b0, done0, done1, err0, err1}, 32'h0);
      Resetn = 1'b1;
      @(negedge clk);

      // Single requester 0: 3 * 5
      set_op(0, 8'h03, 8'h05);
      @(negedge clk);
      check_eq("t32_start", {31'b0, m_Start}, 32'h1);
      check_eq("t32_busy", {31'b0, busy}, 32'h1);
      check_eq("t32_mplier", {24'b0, m_Mplier}, 32'h03);
      wait_pulse(40, flags, cyc);
      check_eq("t32_flags", {28'b0, flags}, 32'h1);
      check_eq("t32_result", {16'b0, result}, 32'h000F);
      check_eq("t32_start_low", {31'b0, m_Start}, 32'h0);
      req0 = 1'b0;
      @(negedge clk);
      check_eq("t32_release_quiet", {28'b0, err1, err0, done1, done0}, 32'h0);
      wait_idle("t32_idle");

      // Single requester 1: -3 * 5
      set_op(1, 8'hFD, 8'h05);
      wait_pulse(40, flags, cyc);
      check_eq("t33_flags", {28'b0, flags}, 32'h2);
      check_eq("t33_result", {16'b0, result}, 32'hFFF1);
      req1 = 1'b0;
      wait_idle("t33_idle");

      // Simultaneous requests straight after reset: requester 0 first
      Resetn = 1'b0;
      @(negedge clk);
      Resetn = 1'b1;
      set_op(0, 8'h02, 8'h03);
      set_op(1, 8'h04, 8'h05);
      wait_pulse(40, flags, cyc);
      check_eq("t34_first", {28'b0, flags}, 32'h1);
      check_eq("t34_res0", {16'b0, result}, 32'h0006);
      req0 = 1'b0;
      wait_pulse(40, flags, cyc);
      check_eq("t34_second", {28'b0, flags}, 32'h2);
      check_eq("t34_res1", {16'b0, result}, 32'h0014);
      req1 = 1'b0;
      wait_idle("t34_idle");

      // Serve 0 alone, so a following tie must go to requester 1
      set_op(0, 8'h01, 8'h01);
      wait_pulse(40, flags, cyc);
      check_eq("t34_solo", {28'b0, flags}, 32'h1);
      req0 = 1'b0;
      wait_idle("t34_solo_idle");
      set_op(0, 8'h02, 8'h03);
      set_op(1, 8'h04, 8'h05);
      wait_pulse(40, flags, cyc);
      check_eq("t34_alt_first", {28'b0, flags}, 32'h2);
      check_eq("t34_alt_res1", {16'b0, result}, 32'h0014);
      req1 = 1'b0;
      wait_pulse(40, flags, cyc);
      check_eq("t34_alt_second", {28'b0, flags}, 32'h1);
      check_eq("t34_alt_res0", {16'b0, result}, 32'h0006);
      req0 = 1'b0;
      wait_idle("t34_alt_idle");

      // Timeout: err0 after the ISSUE cycle plus TIMEOUT wait cycles
      never_fin = 1'b1;
      set_op(0, 8'h09, 8'h09);
      @(negedge clk);
      check_eq("t35_issue", {31'b0, m_Start}, 32'h1);
      wait_pulse(TIMEOUT + 10, flags, cyc);
      check_eq("t35_flags", {28'b0, flags}, 32'h4);
      check_eq("t35_cycles", cyc, TIMEOUT + 1);
      check_eq("t35_result_kept", {16'b0, result}, 32'h0006);
      check_eq("t35_start_low", {31'b0, m_Start}, 32'h0);
      req0 = 1'b0;
      @(negedge clk);
      check_eq("t35_release_quiet", {28'b0, err1, err0, done1, done0}, 32'h0);
      @(negedge clk);
      check_eq("t35_idle", {31'b0, busy}, 32'h0);

      // Operands changed right after grant must not leak through
      never_fin = 1'b0;
      set_op(0, 8'h80, 8'h80);
      @(negedge clk);
      mplier0 = 8'h11;
      mcand0  = 8'h22;
      @(negedge clk);
      check_eq("t37_ops_held", {16'b0, m_Mplier, m_Mcand}, 32'h8080);
      wait_pulse(40, flags, cyc);
      check_eq("t37_flags", {28'b0, flags}, 32'h1);
      check_eq("t37_result", {16'b0, result}, 32'h4000);
      check_eq("t37_ops_still", {16'b0, m_Mplier, m_Mcand}, 32'h8080);
      req0 = 1'b0;
      wait_idle("t37_idle");

      // Reset while stuck in WAIT_FIN
      never_fin = 1'b1;
      set_op(0, 8'h05, 8'h05);
      repeat (4) @(negedge clk);
      check_eq("t36_waiting", {30'b0, busy, m_Start}, 32'h3);
      Resetn = 1'b0;
      req0   = 1'b0;
      @(negedge clk);
      check_eq("t36_start", {31'b0, m_Start}, 32'h0);
      check_eq("t36_busy", {31'b0, busy}, 32'h0);
      check_eq("t36_ops", {16'b0, m_Mplier, m_Mcand}, 32'h0);
      check_eq("t36_result", {16'b0, result}, 32'h0);
      check_eq("t36_no_pulse", {28'b0, err1, err0, done1, done0}, 32'h0);
      Resetn    = 1'b1;
      never_fin = 1'b0;
      @(negedge clk);
      check_eq("t36_no_pulse_after", {28'b0, err1, err0, done1, done0}, 32'h0);
      set_op(0, 8'h07, 8'h06);
      wait_pulse(40, flags, cyc);
      check_eq("t36_flags", {28'b0, flags}, 32'h1);
      check_eq("t36_result_new", {16'b0, result}, 32'h002A);
      req0 = 1'b0;
      wait_idle("t36_idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
